// File: rtl/imem_loader.sv
// imem_loader: streams a program into instruction memory and holds the CPU
// in reset until the halt word has been written.
//
// Ports:
//   CLOCK, RESET       rising-edge clock, asynchronous active-high reset
//   start              one-cycle pulse that begins a (re)load
//   in_valid/in_ready  word handshake; a word moves when both are high
//   in_data            program word
//   imem_we/addr/wdata instruction-memory write port (one pulse per word)
//   cpu_reset          high while the CPU must stay in reset
//   load_done          program loaded, CPU released
//   load_err           last slot used without a terminator
//   word_count         stream words written, terminator included
//
// Build option: define IMEM_PAD_EN to pad memory after the terminator with
// HALT_WORD up to the last address before releasing the CPU.
//
// DEPTH must equal 2**ADDR_W.
module imem_loader #(
    parameter int          ADDR_W    = 8,
    parameter int          DEPTH     = 256,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              start,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   COUNT_MAX = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   COUNT_ONE = (ADDR_W + 1)'(1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
`ifdef IMEM_PAD_EN
        FILL,
`endif
        DONE,
        ERROR
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wptr_q, wptr_d;
    logic                in_ready_q, in_ready_d;
    logic                imem_we_q, imem_we_d;
    logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
    logic [31:0]         imem_wdata_q, imem_wdata_d;
    logic                cpu_reset_q, cpu_reset_d;
    logic                load_done_q, load_done_d;
    logic                load_err_q, load_err_d;
    logic [ADDR_W:0]     word_count_q, word_count_d;
    logic                xfer;

    assign xfer = in_valid && in_ready_q;

    always_comb begin
        state_d      = state_q;
        wptr_d       = wptr_q;
        in_ready_d   = in_ready_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        cpu_reset_d  = cpu_reset_q;
        load_done_d  = load_done_q;
        load_err_d   = load_err_q;
        word_count_d = word_count_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = LOAD;
                    in_ready_d   = 1'b1;
                    wptr_d       = '0;
                    word_count_d = '0;
                    load_err_d   = 1'b0;
                    load_done_d  = 1'b0;
                    cpu_reset_d  = 1'b1;
                end
            end

            LOAD: begin
                if (xfer) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = wptr_q;
                    imem_wdata_d = in_data;
                    if (word_count_q != COUNT_MAX) begin
                        word_count_d = word_count_q + COUNT_ONE;
                    end
                    if (in_data == HALT_WORD) begin
                        in_ready_d = 1'b0;
`ifdef IMEM_PAD_EN
                        if (wptr_q != LAST_ADDR) begin
                            state_d = FILL;
                            wptr_d  = wptr_q + ADDR_ONE;
                        end else begin
                            state_d = DONE;
                        end
`else
                        state_d = DONE;
`endif
                    end else if (wptr_q == LAST_ADDR) begin
                        // Never wrap: the last slot went to a non-terminator.
                        in_ready_d = 1'b0;
                        state_d    = ERROR;
                    end else begin
                        wptr_d = wptr_q + ADDR_ONE;
                    end
                end
            end

`ifdef IMEM_PAD_EN
            FILL: begin
                imem_we_d    = 1'b1;
                imem_addr_d  = wptr_q;
                imem_wdata_d = HALT_WORD;
                if (wptr_q == LAST_ADDR) begin
                    state_d = DONE;
                end else begin
                    wptr_d = wptr_q + ADDR_ONE;
                end
            end
`endif

            DONE, ERROR: begin
                if (start) begin
                    state_d      = LOAD;
                    in_ready_d   = 1'b1;
                    wptr_d       = '0;
                    word_count_d = '0;
                    load_err_d   = 1'b0;
                    load_done_d  = 1'b0;
                    cpu_reset_d  = 1'b1;
                end else if (state_q == DONE) begin
                    // Status flags follow the state by one edge so the
                    // release lands after the final write has committed.
                    load_done_d = 1'b1;
                    cpu_reset_d = 1'b0;
                end else begin
                    load_err_d  = 1'b1;
                    load_done_d = 1'b0;
                    cpu_reset_d = 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q      <= IDLE;
            wptr_q       <= '0;
            in_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_reset_q  <= 1'b1;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            wptr_q       <= wptr_d;
            in_ready_q   <= in_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_reset_q  <= cpu_reset_d;
            load_done_q  <= load_done_d;
            load_err_q   <= load_err_d;
            word_count_q <= word_count_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_reset  = cpu_reset_q;
    assign load_done  = load_done_q;
    assign load_err   = load_err_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed checks of imem_loader (default ADDR_W=8, DEPTH=256).
module tb_imem_loader;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        CLOCK;
    logic        RESET;
    logic        start;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        load_done;
    logic        load_err;
    logic [8:0]  word_count;

    int errors = 0;
    int checks = 0;

    logic [31:0] tb_mem [256];
    int          wr_cnt = 0;

    imem_loader #(.ADDR_W(8), .DEPTH(256), .HALT_WORD(32'hFFFF_FFFF)) dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .load_done  (load_done),
        .load_err   (load_err),
        .word_count (word_count)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    // Memory image as seen by the write port.
    always @(posedge CLOCK) begin
        if (imem_we === 1'b1) begin
            tb_mem[imem_addr] = imem_wdata;
            wr_cnt++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"},   64'(in_ready),   64'd0);
        check({tag, "_we"},         64'(imem_we),    64'd0);
        check({tag, "_addr"},       64'(imem_addr),  64'd0);
        check({tag, "_wdata"},      64'(imem_wdata), 64'd0);
        check({tag, "_cpu_reset"},  64'(cpu_reset),  64'd1);
        check({tag, "_load_done"},  64'(load_done),  64'd0);
        check({tag, "_load_err"},   64'(load_err),   64'd0);
        check({tag, "_word_count"}, 64'(word_count), 64'd0);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (load_done !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        check({tag, "_done_wait"}, 64'(load_done), 64'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        logic [31:0] prog [3];
        int k;
        int base;
        prog[0] = 32'h2008_0005;
        prog[1] = 32'h2009_0003;
        prog[2] = HALT;

        RESET    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        #3;
        check_reset_vals("rst");
        step();
        step();
        RESET = 1'b0;
        step();
        check("idle_cpu_reset", 64'(cpu_reset), 64'd1);

        // --- Test 1: three words, in_valid held high ---
        base = wr_cnt;
        pulse_start();
        check("t1_ready", 64'(in_ready), 64'd1);
        check("t1_we0", 64'(imem_we), 64'd0);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = prog[i];
            step();
            check($sformatf("t1_we_%0d", i), 64'(imem_we), 64'd1);
            check($sformatf("t1_addr_%0d", i), 64'(imem_addr), 64'(i));
            check($sformatf("t1_data_%0d", i), 64'(imem_wdata), 64'(prog[i]));
        end
        in_valid = 1'b0;
        check("t1_ready_drop", 64'(in_ready), 64'd0);
        check("t1_cpu_reset_hold", 64'(cpu_reset), 64'd1);
        check("t1_done_not_yet", 64'(load_done), 64'd0);
`ifndef IMEM_PAD_EN
        step();
        check("t1_we_after", 64'(imem_we), 64'd0);
        check("t1_cpu_released", 64'(cpu_reset), 64'd0);
        check("t1_load_done", 64'(load_done), 64'd1);
        check("t1_wr_cnt", 64'(wr_cnt - base), 64'd3);
`else
        wait_done("t1", 300);
`endif
        check("t1_word_count", 64'(word_count), 64'd3);

        // --- Test 2: same program, in_valid every other cycle ---
        for (int a = 0; a < 3; a++) tb_mem[a] = 32'h0;
        base = wr_cnt;
        pulse_start();
        check("t2_cpu_reset", 64'(cpu_reset), 64'd1);
        check("t2_done_clr", 64'(load_done), 64'd0);
        check("t2_count_clr", 64'(word_count), 64'd0);
        k = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            in_valid = (cyc % 2 == 0);
            in_data  = in_valid ? prog[k] : 32'hDEAD_BEEF;
            step();
            if (cyc % 2 == 0) begin
                check($sformatf("t2_we_%0d", cyc), 64'(imem_we), 64'd1);
                check($sformatf("t2_addr_%0d", cyc), 64'(imem_addr), 64'(k));
                k++;
            end else begin
                check($sformatf("t2_nowe_%0d", cyc), 64'(imem_we), 64'd0);
            end
        end
        in_valid = 1'b0;
        wait_done("t2", 300);
        check("t2_word_count", 64'(word_count), 64'd3);
        for (int a = 0; a < 3; a++)
            check($sformatf("t2_mem_%0d", a), 64'(tb_mem[a]), 64'(prog[a]));
`ifndef IMEM_PAD_EN
        check("t2_wr_cnt", 64'(wr_cnt - base), 64'd3);
`endif

        // --- Test 3: 256 non-terminator words overflow ---
        base = wr_cnt;
        pulse_start();
        in_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            in_data = 32'h1000_0000 + 32'(i);
            step();
            check($sformatf("t3_addr_%0d", i), 64'(imem_addr), 64'(i));
        end
        in_valid = 1'b0;
        check("t3_ready_drop", 64'(in_ready), 64'd0);
        step();
        check("t3_we_after", 64'(imem_we), 64'd0);
        check("t3_load_err", 64'(load_err), 64'd1);
        check("t3_cpu_reset", 64'(cpu_reset), 64'd1);
        check("t3_load_done", 64'(load_done), 64'd0);
        check("t3_in_ready", 64'(in_ready), 64'd0);
        check("t3_word_count", 64'(word_count), 64'd256);
        check("t3_wr_cnt", 64'(wr_cnt - base), 64'd256);

        // --- Test 4: 255 words then terminator at the last address ---
        pulse_start();
        check("t4_err_clr", 64'(load_err), 64'd0);
        in_valid = 1'b1;
        for (int i = 0; i < 255; i++) begin
            in_data = 32'h0000_0100 + 32'(i);
            step();
        end
        in_data = HALT;
        step();
        in_valid = 1'b0;
        check("t4_last_addr", 64'(imem_addr), 64'd255);
        check("t4_last_data", 64'(imem_wdata), 64'(HALT));
        step();
        check("t4_load_done", 64'(load_done), 64'd1);
        check("t4_load_err", 64'(load_err), 64'd0);
        check("t4_cpu_reset", 64'(cpu_reset), 64'd0);
        check("t4_word_count", 64'(word_count), 64'd256);
        check("t4_mem_255", 64'(tb_mem[255]), 64'(HALT));

        // --- Test 5: asynchronous reset mid-load, then full reload ---
        pulse_start();
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_data = 32'h5000_0000 + 32'(i);
            step();
        end
        in_valid = 1'b0;
        #2;
        RESET = 1'b1;
        #1;
        check_reset_vals("t5_async");
        RESET = 1'b0;
        step();
        pulse_start();
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = (i == 4) ? HALT : 32'h6000_0000 + 32'(i);
            step();
            check($sformatf("t5_addr_%0d", i), 64'(imem_addr), 64'(i));
            check($sformatf("t5_data_%0d", i), 64'(imem_wdata),
                  64'((i == 4) ? HALT : 32'h6000_0000 + 32'(i)));
        end
        in_valid = 1'b0;
        wait_done("t5", 300);
        check("t5_word_count", 64'(word_count), 64'd5);

`ifdef IMEM_PAD_EN
        // --- Test 6: padding after a terminator at address 1 ---
        base = wr_cnt;
        pulse_start();
        in_valid = 1'b1;
        in_data  = 32'h2008_0005;
        step();
        in_data  = HALT;
        step();
        in_valid = 1'b0;
        for (int a = 2; a < 256; a++) begin
            step();
            check($sformatf("t6_fill_%0d", a), {31'd0, imem_we, 24'd0, imem_addr},
                  {31'd0, 1'b1, 24'd0, 8'(a)});
            check($sformatf("t6_hold_%0d", a), {62'd0, in_ready, cpu_reset}, 64'd1);
        end
        check("t6_fill_data", 64'(imem_wdata), 64'(HALT));
        step();
        check("t6_load_done", 64'(load_done), 64'd1);
        check("t6_word_count", 64'(word_count), 64'd2);
        check("t6_wr_cnt", 64'(wr_cnt - base), 64'd256);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Writer-side counterpart to the pipeline CPU's instruction fetch. It accepts a program as a stream of 32-bit words over a valid/ready handshake and writes them into instruction memory from word address 0. It holds the CPU in reset while loading. It releases the CPU once the halt word 32'hFFFF_FFFF has been written, the same word the CPU bench treats as end-of-program.

Parameters:
ADDR_W, 8, instruction-memory word-address width
DEPTH, 256, number of instruction words; must equal 2**ADDR_W
HALT_WORD, 32'hFFFF_FFFF, program terminator value

Ports:
CLOCK  input  1  system clock, rising edge
RESET  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse; begins a (re)load
in_valid  input  1  producer has a word on in_data
in_data  input  32  program word
in_ready  output  1  loader can accept a word this cycle
imem_we  output  1  instruction-memory write enable
imem_addr  output  ADDR_W  word address of the write
imem_wdata  output  32  data written
cpu_reset  output  1  holds the CPU in reset while high
load_done  output  1  program loaded, CPU released
load_err  output  1  program did not fit (no terminator slot)
word_count  output  ADDR_W+1  words written from the stream, terminator included

Behaviour:
- All outputs are registered.
- Reset values:
  - in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0
  - cpu_reset=1, load_done=0, load_err=0, word_count=0
  - state=IDLE
- RESET asserted mid-load aborts immediately to these values.
- Handshake:
  - A word transfers on a rising edge where in_valid && in_ready.
  - in_ready is high only in LOAD; it drops in the cycle after the terminator or overflow word is accepted.
  - in_data is ignored when no transfer occurs.
- Write latency: a word accepted at edge N drives imem_we=1 with its imem_addr/imem_wdata during cycle N..N+1, committed at edge N+1. imem_we is a one-cycle pulse per word. No write occurs without a transfer, except FILL (Optional Feature).
- States:
  - IDLE: cpu_reset=1. start -> LOAD; wptr=0, word_count=0, load_err=0, load_done=0.
  - LOAD: in_ready=1. On transfer, write word at wptr; word_count++. Then:
    - word==HALT_WORD -> FILL (if the macro is defined and wptr<DEPTH-1), otherwise -> DONE.
    - else if wptr==DEPTH-1 -> ERROR (last slot used without a terminator).
    - else wptr++.
  - FILL: see Optional Feature.
  - DONE: load_done=1, cpu_reset=0. Both change on the edge after the terminator write commits, i.e. cpu_reset falls one cycle after the final imem_we pulse.
  - ERROR: load_err=1, cpu_reset=1, load_done=0.
  - From DONE or ERROR, start -> LOAD. cpu_reset reasserts on the same edge; load_done and load_err clear.
- start in LOAD or FILL is ignored.
- start and in_valid in the same IDLE cycle: no transfer that cycle.
- Address never wraps; overflow is ERROR, not wrap to 0.
- word_count saturates at DEPTH.

Optional Feature:
Macro IMEM_PAD_EN.
- Defined:
  - After the terminator is written at address t with t<DEPTH-1, enter FILL.
  - FILL writes HALT_WORD to addresses t+1..DEPTH-1, one per cycle (imem_we held high), then -> DONE.
  - in_ready=0 and cpu_reset=1 throughout FILL.
  - word_count excludes fill writes.
- Undefined:
  - FILL does not exist; the terminator goes straight to DONE.
  - Memory beyond the terminator is left untouched.

Test Plan:
- Reset, then start; stream 3 words: 0x2008_0005, 0x2009_0003, 0xFFFF_FFFF, in_valid always high.
  - imem_we pulses at addr 0, 1, 2 on consecutive cycles.
  - word_count=3; cpu_reset falls one cycle after the addr-2 write; load_done=1.
- Same program with in_valid toggled every other cycle.
  - Identical memory contents and word_count=3.
  - No imem_we in cycles without a transfer.
- Stream 256 non-terminator words (DEPTH=256).
  - Writes cover 0..255, then ERROR: load_err=1, cpu_reset=1, in_ready=0, word_count=256.
- Stream 255 non-terminator words, then 0xFFFF_FFFF.
  - Terminator written at addr 255; DONE; load_err=0.
- Assert RESET after 2 of 5 words.
  - All outputs return to reset values within the same cycle (asynchronous).
  - start and the full reload then succeed from addr 0.
- With IMEM_PAD_EN: program of 2 words ending in terminator (terminator at addr 1).
  - Writes of 0xFFFF_FFFF to addrs 2..255 (254 cycles), then load_done=1.
  - word_count stays 2.
